// File: rtl/sram_bus_controller.sv
// Single-byte read/write initiator for a 32Kx8 asynchronous SRAM.
// Sequences nCS/nOE/nWE with programmable setup, pulse and read intervals.
module sram_bus_controller #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int WE_CYC    = 2,
    parameter int READ_CYC  = 2
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d_write,
    input  logic [DATA_W-1:0] sram_d_read,
    output logic              sram_nCS,
    output logic              sram_nOE,
    output logic              sram_nWE
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_SETUP,
        R_OE,
        R_DONE
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WE_LD    = 4'(WE_CYC - 1);
    localparam logic [3:0] READ_LD  = 4'(READ_CYC - 1);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                ncs_reg, ncs_next;
    logic                noe_reg, noe_next;
    logic                nwe_reg, nwe_next;
    logic                resp_valid_reg, resp_valid_next;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = (cnt_reg != 4'd0) ? cnt_reg - 4'd1 : 4'd0;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next = req_addr;
                    cnt_next  = SETUP_LD;
                    if (req_write) begin
                        wdata_next = req_wdata;
                        state_next = W_SETUP;
                    end else begin
                        state_next = R_SETUP;
                    end
                end
            end
            W_SETUP: begin
                if (cnt_reg == 4'd0) begin
                    state_next = W_PULSE;
                    cnt_next   = WE_LD;
                end
            end
            W_PULSE: begin
                if (cnt_reg == 4'd0) begin
                    state_next = W_HOLD;
                end
            end
            W_HOLD: state_next = IDLE;
            R_SETUP: begin
                if (cnt_reg == 4'd0) begin
                    state_next = R_OE;
                    cnt_next   = READ_LD;
                end
            end
            R_OE: begin
                // Data is sampled on the edge that closes the final nOE-low cycle.
                if (cnt_reg == 4'd0) begin
                    rdata_next = sram_d_read;
                    state_next = R_DONE;
                end
            end
            R_DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Strobes are registered, so they are decoded from the state being entered.
        ncs_next        = !(state_next inside {W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_OE});
        nwe_next        = (state_next != W_PULSE);
        noe_next        = (state_next != R_OE);
        resp_valid_next = (state_next inside {W_HOLD, R_DONE});
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            ncs_reg        <= 1'b1;
            noe_reg        <= 1'b1;
            nwe_reg        <= 1'b1;
            resp_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            ncs_reg        <= ncs_next;
            noe_reg        <= noe_next;
            nwe_reg        <= nwe_next;
            resp_valid_reg <= resp_valid_next;
        end
    end

    assign req_ready    = (state_reg == IDLE);
    assign resp_valid   = resp_valid_reg;
    assign resp_rdata   = rdata_reg;
    assign sram_a       = addr_reg;
    assign sram_d_write = wdata_reg;
    assign sram_nCS     = ncs_reg;
    assign sram_nOE     = noe_reg;
    assign sram_nWE     = nwe_reg;

endmodule

// File: tb/tb_sram_bus_controller.sv
// Bench for sram_bus_controller: behavioural SRAM, vector table, scoreboard
// queue of accepted requests and a per-cycle protocol monitor.
module tb_sram_bus_controller;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 8;
    localparam int SETUP_CYC = 1;
    localparam int WE_CYC    = 2;
    localparam int READ_CYC  = 2;
    localparam int LAT_W     = SETUP_CYC + WE_CYC + 1;
    localparam int LAT_R     = SETUP_CYC + READ_CYC + 1;

    logic              clk = 1'b0;
    logic              nRST;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d_write;
    logic [DATA_W-1:0] sram_d_read;
    logic              sram_nCS;
    logic              sram_nOE;
    logic              sram_nWE;

    int total = 0;
    int bad   = 0;

    sram_bus_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETUP_CYC(SETUP_CYC),
        .WE_CYC(WE_CYC), .READ_CYC(READ_CYC)
    ) dut (
        .clk(clk), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_a(sram_a), .sram_d_write(sram_d_write), .sram_d_read(sram_d_read),
        .sram_nCS(sram_nCS), .sram_nOE(sram_nOE), .sram_nWE(sram_nWE)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: commits on the rising edge of nWE, drives only while selected.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge sram_nWE) begin
        if (!sram_nCS) mem[sram_a] = sram_d_write;
    end
    assign sram_d_read = (!sram_nCS && !sram_nOE) ? mem[sram_a] : 8'hC3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        int                acc_edge;
    } sb_t;

    sb_t               q[$];
    logic [DATA_W-1:0] cur_exp  = '0;
    logic [DATA_W-1:0] last_wd  = '0;
    logic [DATA_W-1:0] last_rd  = '0;
    int                edge_n   = 0;
    int                we_cnt   = 0;
    int                oe_cnt   = 0;

    // Accept captured on the edge, protocol checked 4ns later (before the driver's negedge).
    always begin
        sb_t e;
        @(posedge clk);
        edge_n++;
        if (nRST && req_valid && req_ready) begin
            chk("one_in_flight", 32'(q.size()), 32'd0);
            e.wr        = req_write;
            e.addr      = req_addr;
            e.wdata     = req_write ? req_wdata : last_wd;
            e.exp_rdata = cur_exp;
            e.acc_edge  = edge_n;
            if (req_write) last_wd = req_wdata;
            q.push_back(e);
            we_cnt = 0;
            oe_cnt = 0;
        end
        #4;
        if (!nRST) begin
            q.delete();
            last_wd = '0;
            last_rd = '0;
        end else begin
            chk("we_oe_overlap", 32'(!sram_nWE && !sram_nOE), 32'd0);
            chk("we_without_cs", 32'(!sram_nWE && sram_nCS), 32'd0);
            chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
            if (q.size() == 0) begin
                chk("idle_ncs", 32'(sram_nCS), 32'd1);
                if (resp_valid) chk("spurious_resp", 32'(resp_valid), 32'd0);
            end else begin
                chk("addr_stable", 32'(sram_a), 32'(q[0].addr));
                chk("wdata_stable", 32'(sram_d_write), 32'(q[0].wdata));
                if (!sram_nWE) we_cnt++;
                if (!sram_nOE) oe_cnt++;
                if (resp_valid) begin
                    e = q.pop_front();
                    chk("latency", 32'(edge_n + 1 - e.acc_edge), 32'(e.wr ? LAT_W : LAT_R));
                    if (e.wr) begin
                        chk("nwe_low_cycles", 32'(we_cnt), 32'(WE_CYC));
                        chk("rdata_kept_on_write", 32'(resp_rdata), 32'(last_rd));
                    end else begin
                        chk("noe_low_cycles", 32'(oe_cnt), 32'(READ_CYC));
                        chk("rdata", 32'(resp_rdata), 32'(e.exp_rdata));
                        last_rd = e.exp_rdata;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(req_ready && q.size() == 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        cur_exp   = exp;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        $display("req %s addr=%04h wdata=%02h exp_rdata=%02h", wr ? "W" : "R", a, d, exp);
    endtask

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              hold;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{1'b1, 15'h0064, 8'hFA, 8'h00, 1'b0};
        vt[1]  = '{1'b0, 15'h0064, 8'h00, 8'hFA, 1'b0};
        vt[2]  = '{1'b1, 15'h7FFF, 8'h55, 8'h00, 1'b1};
        vt[3]  = '{1'b1, 15'h0000, 8'hAA, 8'h00, 1'b1};
        vt[4]  = '{1'b0, 15'h7FFF, 8'h00, 8'h55, 1'b1};
        vt[5]  = '{1'b0, 15'h0000, 8'h00, 8'hAA, 1'b0};
        vt[6]  = '{1'b1, 15'h1234, 8'h3C, 8'h00, 1'b0};
        vt[7]  = '{1'b1, 15'h1235, 8'hC3, 8'h00, 1'b0};
        vt[8]  = '{1'b0, 15'h1235, 8'h00, 8'hC3, 1'b0};
        vt[9]  = '{1'b0, 15'h1234, 8'h00, 8'h3C, 1'b0};
        vt[10] = '{1'b1, 15'h0064, 8'h01, 8'h00, 1'b0};
        vt[11] = '{1'b0, 15'h0064, 8'h00, 8'h01, 1'b0};

        nRST = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        #12;
        chk("rst_ncs", 32'(sram_nCS), 32'd1);
        chk("rst_noe", 32'(sram_nOE), 32'd1);
        chk("rst_nwe", 32'(sram_nWE), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_addr", 32'(sram_a), 32'd0);
        chk("rst_wdata", 32'(sram_d_write), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_rdata);
            if (!vt[i].hold) begin
                req_valid = 1'b0;
                wait_idle();
            end
        end

        // Request inputs wiggle while busy; the transaction must be unaffected.
        issue(1'b1, 15'h2222, 8'h99, 8'h00);
        for (int n = 0; n < 20 && !resp_valid; n++) begin
            req_write = 1'($urandom);
            req_addr  = 15'($urandom);
            req_wdata = 8'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_idle();
        issue(1'b0, 15'h2222, 8'h00, 8'h99);
        req_valid = 1'b0;
        wait_idle();

        // Reset while nOE is low: strobes must rise at once, no response afterwards.
        issue(1'b0, 15'h0064, 8'h00, 8'h01);
        req_valid = 1'b0;
        for (int n = 0; n < 20 && sram_nOE; n++) @(negedge clk);
        chk("reached_r_oe", 32'(sram_nOE), 32'd0);
        @(posedge clk);
        #2 nRST = 1'b0;
        #1;
        chk("midrst_ncs", 32'(sram_nCS), 32'd1);
        chk("midrst_noe", 32'(sram_nOE), 32'd1);
        chk("midrst_nwe", 32'(sram_nWE), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b0, 15'h0064, 8'h00, 8'h01);
        req_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
